mode_ctrl: RTL and testbench

Front-panel controller for the Spartan-3 clock. It conditions the three raw push-buttons and sequences the display/edit mode that drives the `state[3:0]` bus into the time-keeping, alarm-setting and stopwatch datapaths. It owns the alarm-enable flag, and it runs the alarm ringing, snooze and dismiss sequence from the alarm comparator's match output.

---
 rtl/mode_ctrl_if.sv | 33 +++
 rtl/mode_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_mode_ctrl.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mode_ctrl_if.sv
// mode_ctrl_if: front-panel bus between the clock's button/alarm sources and
// the mode controller.
//   b1, b2, b3   raw bouncing push-buttons (high = pressed)
//   tick_1hz     one-clk pulse per second
//   match        alarm comparator level (current time == alarm time)
//   state        display/edit mode (0 CLOCK, 1 TIME_SET, 2 ALARM_SET, 3 STOPWATCH)
//   alarmon      alarm armed
//   b1_pulse,
//   b2_pulse     debounced press pulses forwarded to the datapaths
//   ringing      alarm currently ringing
//   buzz         piezo drive
interface mode_ctrl_if;
  logic       b1, b2, b3;
  logic       tick_1hz;
  logic       match;
  logic [3:0] state;
  logic       alarmon;
  logic       b1_pulse, b2_pulse;
  logic       ringing;
  logic       buzz;

  // panel side: drives buttons, tick and match, observes the controller
  modport master (
    output b1, b2, b3, tick_1hz, match,
    input  state, alarmon, b1_pulse, b2_pulse, ringing, buzz
  );

  // controller side
  modport slave (
    input  b1, b2, b3, tick_1hz, match,
    output state, alarmon, b1_pulse, b2_pulse, ringing, buzz
  );
endinterface

// File: rtl/mode_ctrl.sv
// mode_ctrl: front-panel controller for the clock. Debounces the three
// buttons, sequences the display/edit mode, owns the alarm-enable flag and
// runs the alarm ring / snooze / dismiss sequence.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-low
//   bus    mode_ctrl_if.slave (buttons, tick_1hz, match in; mode/alarm out)

// One button: two-flop synchronizer, disagreement counter, rising-edge pulse.
module mode_ctrl_debounce #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic press
);
  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic          s1, s2, deb, deb_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      deb   <= 1'b0;
      deb_d <= 1'b0;
      cnt   <= '0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      deb_d <= deb;
      // any cycle of agreement restarts the count, so only an unbroken run
      // of DEB_CYCLES disagreeing samples flips the debounced level
      if (s2 != deb) begin
        if (cnt == CW'(DEB_CYCLES - 1)) begin
          deb <= s2;
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign press = deb & ~deb_d;
endmodule

module mode_ctrl #(
  parameter int DEB_CYCLES = 500000,
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300
) (
  input logic        clk,
  input logic        reset,
  mode_ctrl_if.slave bus
);
  localparam int SEC_MAX = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
  localparam int SW      = $clog2(SEC_MAX + 1);
  localparam logic [SW-1:0] RING_LAST   = SW'(RING_SEC - 1);
  localparam logic [SW-1:0] SNOOZE_LAST = SW'(SNOOZE_SEC - 1);

  typedef enum logic [1:0] {M_CLOCK, M_TSET, M_ASET, M_SWATCH} mode_t;
  typedef enum logic [1:0] {A_IDLE, A_RING, A_SNOOZE}          alarm_t;

  // ---- button conditioning ----
  logic [2:0] raw, p;   // p[0]=p1, p[1]=p2, p[2]=p3
  assign raw = {bus.b3, bus.b2, bus.b1};

  for (genvar i = 0; i < 3; i++) begin : g_btn
    mode_ctrl_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk   (clk),
      .reset (reset),
      .raw   (raw[i]),
      .press (p[i])
    );
  end

  // ---- state ----
  mode_t         mode, mode_n;
  alarm_t        ast, ast_n;
  logic [SW-1:0] sec, sec_n;
  logic          phase, phase_n;      // 0 = beep on
  logic          alarmon, alarmon_n;
  logic          b1p, b1p_n, b2p, b2p_n;
  logic          match_q, match_d;
  logic          match_rise;

  assign match_rise = match_q & ~match_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode    <= M_CLOCK;
      ast     <= A_IDLE;
      sec     <= '0;
      phase   <= 1'b0;
      alarmon <= 1'b0;
      b1p     <= 1'b0;
      b2p     <= 1'b0;
      match_q <= 1'b0;
      match_d <= 1'b0;
    end else begin
      mode    <= mode_n;
      ast     <= ast_n;
      sec     <= sec_n;
      phase   <= phase_n;
      alarmon <= alarmon_n;
      b1p     <= b1p_n;
      b2p     <= b2p_n;
      match_q <= bus.match;
      match_d <= match_q;
    end
  end

  always_comb begin
    mode_n    = mode;
    ast_n     = ast;
    sec_n     = sec;
    phase_n   = phase;
    alarmon_n = alarmon;
    b1p_n     = 1'b0;
    b2p_n     = 1'b0;
    unique case (ast)
      A_IDLE: begin
        if (p[2]) begin
          unique case (mode)
            M_CLOCK:  mode_n = M_TSET;
            M_TSET:   mode_n = M_ASET;
            M_ASET:   mode_n = M_SWATCH;
            default:  mode_n = M_CLOCK;
          endcase
        end
        if (p[0] && mode == M_CLOCK) alarmon_n = ~alarmon;
        b1p_n = p[0] && (mode != M_CLOCK);
        b2p_n = p[1] && (mode != M_CLOCK);
        // evaluated independently of the mode logic so a match edge landing
        // on a mode change is not lost
        if (match_rise && alarmon) begin
          ast_n   = A_RING;
          sec_n   = '0;
          phase_n = 1'b0;
        end
      end
      A_RING: begin
        // priority: disarm, dismiss, snooze, then timeout
        if (!alarmon || p[0] || p[2]) begin
          ast_n = A_IDLE;
          sec_n = '0;
        end else if (p[1]) begin
          ast_n = A_SNOOZE;
          sec_n = '0;
        end else if (bus.tick_1hz) begin
          if (sec == RING_LAST) begin
            ast_n = A_IDLE;
            sec_n = '0;
          end else begin
            sec_n   = sec + 1'b1;
            phase_n = ~phase;
          end
        end
      end
      A_SNOOZE: begin
        if (!alarmon) begin
          ast_n = A_IDLE;
          sec_n = '0;
        end else if (bus.tick_1hz) begin
          if (sec == SNOOZE_LAST) begin
            ast_n   = A_RING;
            sec_n   = '0;
            phase_n = 1'b0;
          end else begin
            sec_n = sec + 1'b1;
          end
        end
      end
      default: begin
        ast_n = A_IDLE;
        sec_n = '0;
      end
    endcase
  end

  assign bus.state    = {2'b00, mode};
  assign bus.alarmon  = alarmon;
  assign bus.b1_pulse = b1p;
  assign bus.b2_pulse = b2p;
  assign bus.ringing  = (ast == A_RING);
  assign bus.buzz     = (ast == A_RING) & ~phase;
endmodule

// File: tb/tb_mode_ctrl.sv
module tb_mode_ctrl;
  localparam int D  = 4;
  localparam int RS = 3;
  localparam int SS = 2;

  localparam int P1 = 1, P2 = 2, P3 = 3, TK = 4, MU = 5, MD = 6;

  logic clk = 1'b0;
  logic reset = 1'b0;
  mode_ctrl_if bus();

  mode_ctrl #(.DEB_CYCLES(D), .RING_SEC(RS), .SNOOZE_SEC(SS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int n_b1 = 0, n_b2 = 0, n_chg = 0;
  logic [3:0] st_prev = '0;

  always @(negedge clk) begin
    if (bus.b1_pulse === 1'b1) n_b1++;
    if (bus.b2_pulse === 1'b1) n_b2++;
    if (bus.state !== st_prev) n_chg++;
    st_prev = bus.state;
  end

  // behavioural model: mode number, armed flag, alarm phase, seconds elapsed
  int m_mode, m_al, m_ring, m_snz, m_el, m_match, e_b1, e_b2;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_mode = 0; m_al = 0; m_ring = 0; m_snz = 0; m_el = 0; m_match = 0;
    e_b1 = n_b1; e_b2 = n_b2;
  endtask

  task automatic do_reset();
    bus.b1 = 0; bus.b2 = 0; bus.b3 = 0; bus.tick_1hz = 0; bus.match = 0;
    reset = 0;
    cyc(3);
    reset = 1;
    cyc(2);
    model_reset();
  endtask

  task automatic set_btn(input int k, input logic v);
    case (k)
      1: bus.b1 = v;
      2: bus.b2 = v;
      default: bus.b3 = v;
    endcase
  endtask

  task automatic model(input int a);
    case (a)
      P1, P2, P3: begin
        if (m_ring != 0) begin
          m_ring = 0; m_el = 0;
          if (a == P2) m_snz = 1;
        end else if (m_snz == 0) begin
          if (a == P3) m_mode = (m_mode + 1) % 4;
          else if (m_mode == 0) begin
            if (a == P1) m_al = 1 - m_al;
          end else if (a == P1) e_b1++;
          else e_b2++;
        end
      end
      TK: begin
        if (m_ring != 0) begin
          m_el++;
          if (m_el >= RS) begin m_ring = 0; m_el = 0; end
        end else if (m_snz != 0) begin
          m_el++;
          if (m_el >= SS) begin m_snz = 0; m_ring = 1; m_el = 0; end
        end
      end
      MU: begin
        if (m_match == 0 && m_ring == 0 && m_snz == 0 && m_al != 0) begin
          m_ring = 1; m_el = 0;
        end
        m_match = 1;
      end
      default: m_match = 0;
    endcase
  endtask

  task automatic act(input int a);
    case (a)
      P1, P2, P3: begin
        set_btn(a, 1'b1); cyc(D + 6);
        set_btn(a, 1'b0); cyc(D + 6);
      end
      TK: begin
        bus.tick_1hz = 1; cyc(1);
        bus.tick_1hz = 0; cyc(2);
      end
      MU: begin bus.match = 1; cyc(3); end
      default: begin bus.match = 0; cyc(3); end
    endcase
    model(a);
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".state"},   bus.state,    m_mode);
    chk({tag, ".alarmon"}, bus.alarmon,  m_al);
    chk({tag, ".ringing"}, bus.ringing,  m_ring);
    chk({tag, ".buzz"},    bus.buzz,     (m_ring != 0 && (m_el % 2) == 0) ? 1 : 0);
    chk({tag, ".b1cnt"},   n_b1,         e_b1);
    chk({tag, ".b2cnt"},   n_b2,         e_b2);
  endtask

  typedef struct {
    int a;
    int st;
    int al;
    int rg;
    int bz;
  } vec_t;

  vec_t tv[22];

  initial begin
    int c0;
    tv[0]  = '{P3, 1, 0, 0, 0};
    tv[1]  = '{P3, 2, 0, 0, 0};
    tv[2]  = '{P2, 2, 0, 0, 0};   // one b2_pulse expected
    tv[3]  = '{P3, 3, 0, 0, 0};
    tv[4]  = '{P3, 0, 0, 0, 0};
    tv[5]  = '{P2, 0, 0, 0, 0};   // no b2_pulse in CLOCK
    tv[6]  = '{P1, 0, 1, 0, 0};   // arm
    tv[7]  = '{MU, 0, 1, 1, 1};
    tv[8]  = '{TK, 0, 1, 1, 0};
    tv[9]  = '{TK, 0, 1, 1, 1};
    tv[10] = '{TK, 0, 1, 0, 0};   // timeout at 3rd tick
    tv[11] = '{TK, 0, 1, 0, 0};   // match still high: no re-ring
    tv[12] = '{MD, 0, 1, 0, 0};
    tv[13] = '{MU, 0, 1, 1, 1};
    tv[14] = '{P2, 0, 1, 0, 0};   // snooze
    tv[15] = '{TK, 0, 1, 0, 0};
    tv[16] = '{TK, 0, 1, 1, 1};   // back to ring after 2 ticks
    tv[17] = '{P1, 0, 1, 0, 0};   // dismiss, no toggle
    tv[18] = '{MD, 0, 1, 0, 0};
    tv[19] = '{P1, 0, 0, 0, 0};   // disarm
    tv[20] = '{MU, 0, 0, 0, 0};   // edge while disarmed
    tv[21] = '{MD, 0, 0, 0, 0};

    bus.b1 = 0; bus.b2 = 0; bus.b3 = 0; bus.tick_1hz = 0; bus.match = 0;
    #2;
    chk("reset.state",   bus.state,    0);
    chk("reset.alarmon", bus.alarmon,  0);
    chk("reset.ringing", bus.ringing,  0);
    chk("reset.buzz",    bus.buzz,     0);
    chk("reset.b1p",     bus.b1_pulse, 0);
    chk("reset.b2p",     bus.b2_pulse, 0);
    do_reset();

    // bounce: 2-cycle bounces never satisfy the filter, final hold advances once
    c0 = n_chg;
    for (int i = 0; i < 6; i++) begin
      bus.b3 = ~bus.b3; cyc(2);
    end
    bus.b3 = 1; cyc(10);
    bus.b3 = 0; cyc(10);
    chk("bounce.state", bus.state, 1);
    chk("bounce.changes", n_chg - c0, 1);

    // match latency and timeout edge timing
    do_reset();
    act(P1);
    bus.match = 1;
    cyc(1);
    chk("lat.ring_c1", bus.ringing, 0);
    cyc(1);
    chk("lat.ring_c2", bus.ringing, 1);
    chk("lat.buzz_c2", bus.buzz, 1);
    for (int t = 0; t < RS; t++) begin
      cyc(1);
      bus.tick_1hz = 1;
      cyc(1);
      bus.tick_1hz = 0;
      chk($sformatf("tmo.ring_t%0d", t + 1), bus.ringing, (t == RS - 1) ? 0 : 1);
    end

    // reset mid-ring takes effect without a clock edge
    do_reset();
    act(P1);
    act(MU);
    chk("mid.ring_before", bus.ringing, 1);
    #2 reset = 0;
    #1;
    chk("mid.alarmon", bus.alarmon, 0);
    chk("mid.ringing", bus.ringing, 0);
    chk("mid.buzz",    bus.buzz,    0);
    chk("mid.state",   bus.state,   0);
    cyc(1);
    reset = 1;
    cyc(2);
    model_reset();
    bus.match = 0; cyc(3);
    act(MU);
    chk("mid.after_ring", bus.ringing, 0);
    act(MD);

    // directed vector table
    do_reset();
    for (int i = 0; i < 22; i++) begin
      act(tv[i].a);
      chk($sformatf("tv%0d.state", i),   bus.state,   tv[i].st);
      chk($sformatf("tv%0d.alarmon", i), bus.alarmon, tv[i].al);
      chk($sformatf("tv%0d.ringing", i), bus.ringing, tv[i].rg);
      chk($sformatf("tv%0d.buzz", i),    bus.buzz,    tv[i].bz);
      chk($sformatf("tv%0d.b1cnt", i),   n_b1,        e_b1);
      chk($sformatf("tv%0d.b2cnt", i),   n_b2,        e_b2);
    end

    // randomized actions against the model
    do_reset();
    for (int i = 0; i < 250; i++) begin
      act(int'($urandom_range(1, 6)));
      check_model($sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
